// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sub_pkg
// Description : Shared constants for the pipelined slice subtractor.
//               DEFAULT_WIDTH / DEFAULT_SLICE_W are the parameter defaults
//               of sub_32bit_pipe; DEFAULT_NSTAGE is the matching stage
//               count (one pipeline stage per slice).
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SLICE_W = 8;
    localparam int DEFAULT_NSTAGE  = DEFAULT_WIDTH / DEFAULT_SLICE_W;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/sub_slice.sv
`default_nettype none
// ============================================================================
// Module      : sub_slice
// Description : Purely combinational SLICE_W-bit subtract with borrow chain.
//               diff = (a - b - borrow_in) mod 2^SLICE_W,
//               borrow_out = 1 when the true result is negative.
// Ports       : a, b        - slice operands
//               borrow_in   - borrow from the next-lower slice
//               diff        - slice result
//               borrow_out  - borrow into the next-higher slice
// Revision    : 1.0 - initial release
// ============================================================================
module sub_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] diff,
    output logic               borrow_out
);

    // One extra bit catches the borrow: the subtraction wraps to a value with
    // the top bit set exactly when a < b + borrow_in.
    logic [SLICE_W:0] w_full;

    assign w_full     = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, borrow_in};
    assign diff       = w_full[SLICE_W-1:0];
    assign borrow_out = w_full[SLICE_W];

endmodule : sub_slice
`default_nettype wire

// File: rtl/sub_32bit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sub_32bit_pipe
// Description : Valid/ready pipelined unsigned subtractor. Stage k resolves
//               diff slice k using the borrow registered by stage k-1, so a
//               beat takes NSTAGE = WIDTH/SLICE_W cycles to emerge. WIDTH
//               must be an integer multiple of SLICE_W.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - upstream handshake (a, b)
//               a, b                - unsigned minuend / subtrahend
//               out_valid/out_ready - downstream handshake (diff, borrow)
//               diff                - (a - b) mod 2^WIDTH
//               borrow              - 1 iff a < b
// Revision    : 1.0 - initial release
// ============================================================================
module sub_32bit_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SLICE_W = DEFAULT_SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NSTAGE = WIDTH / SLICE_W;

    // Stage registers. r_a/r_b carry the operands forward so later stages can
    // resolve their upper slices; r_d accumulates the resolved low slices.
    logic [NSTAGE-1:0]            r_valid;
    logic [NSTAGE-1:0]            r_borrow;
    logic [NSTAGE-1:0][WIDTH-1:0] r_a;
    logic [NSTAGE-1:0][WIDTH-1:0] r_b;
    logic [NSTAGE-1:0][WIDTH-1:0] r_d;

    // Per-stage inputs (from ports for stage 0, from stage k-1 otherwise)
    logic [NSTAGE-1:0]              w_v_in;
    logic [NSTAGE-1:0]              w_bin;
    logic [NSTAGE-1:0][WIDTH-1:0]   w_a_in;
    logic [NSTAGE-1:0][WIDTH-1:0]   w_b_in;
    logic [NSTAGE-1:0][WIDTH-1:0]   w_d_in;
    logic [NSTAGE-1:0][WIDTH-1:0]   w_d_next;
    logic [NSTAGE-1:0][SLICE_W-1:0] w_sdiff;
    logic [NSTAGE-1:0]              w_bout;
    logic                           w_en;

    // The whole pipe advances together; it only stalls when a result is
    // sitting at the output and downstream is not taking it.
    assign w_en     = !r_valid[NSTAGE-1] || out_ready;
    assign in_ready = w_en;

    always_comb begin
        w_v_in[0] = in_valid;
        w_a_in[0] = a;
        w_b_in[0] = b;
        w_d_in[0] = '0;
        w_bin[0]  = 1'b0;
        for (int k = 1; k < NSTAGE; k++) begin
            w_v_in[k] = r_valid[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_d_in[k] = r_d[k-1];
            w_bin[k]  = r_borrow[k-1];
        end
    end

    // Merge each stage's freshly resolved slice into the running result.
    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            w_d_next[k]                        = w_d_in[k];
            w_d_next[k][k*SLICE_W +: SLICE_W]  = w_sdiff[k];
        end
    end

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            sub_slice #(
                .SLICE_W (SLICE_W)
            ) u_slice (
                .a          (w_a_in[k][k*SLICE_W +: SLICE_W]),
                .b          (w_b_in[k][k*SLICE_W +: SLICE_W]),
                .borrow_in  (w_bin[k]),
                .diff       (w_sdiff[k]),
                .borrow_out (w_bout[k])
            );
        end
    endgenerate

    // Bubbles still latch whatever is on a/b; their valid bit is 0 so that
    // data never reaches a consumer and never touches neighbouring beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= '0;
            r_borrow <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
        end else if (w_en) begin
            r_valid  <= w_v_in;
            r_borrow <= w_bout;
            r_a      <= w_a_in;
            r_b      <= w_b_in;
            r_d      <= w_d_next;
        end
    end

    assign out_valid = r_valid[NSTAGE-1];
    assign diff      = r_d[NSTAGE-1];
    assign borrow    = r_borrow[NSTAGE-1];

    // Operands have nothing left to resolve after the final stage.
    logic w_unused;
    assign w_unused = ^{r_a[NSTAGE-1], r_b[NSTAGE-1]};

endmodule : sub_32bit_pipe
`default_nettype wire

// File: doc/sub_32bit_pipe.md
SUB_32BIT_PIPE -- requirements
Module: sub_32bit_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; SHALL be a multiple of SLICE_W.
REQ-002 Parameter SLICE_W, default 8: bits resolved per pipeline stage.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: upstream beat present.
REQ-006 Port in_ready  output  1: block can accept a beat this cycle.
REQ-007 Port a  input  WIDTH: unsigned minuend.
REQ-008 Port b  input  WIDTH: unsigned subtrahend.
REQ-009 Port out_valid  output  1: result beat present.
REQ-010 Port out_ready  input  1: downstream accepts result this cycle.
REQ-011 Port diff  output  WIDTH: (a - b) mod 2^WIDTH.
REQ-012 Port borrow  output  1: final borrow; 1 iff a < b unsigned.

Function
REQ-013 Pipeline SHALL have NSTAGE = WIDTH/SLICE_W register stages (4 at defaults); stage k SHALL resolve diff bits [SLICE_W*k+SLICE_W-1 : SLICE_W*k] using the borrow registered by stage k-1 (stage 0 borrow-in = 0).
REQ-014 Each stage SHALL register: its valid bit, the resolved low result bits so far, the still-unresolved upper bits of a and b, and its borrow-out.
REQ-015 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-016 A beat SHALL be accepted on an edge where in_valid && in_ready; when en=1 and in_valid=0, a bubble (valid=0) SHALL enter stage 0.
REQ-017 When en=0, all stage registers SHALL hold; diff, borrow, out_valid SHALL stay stable while out_valid && !out_ready.
REQ-018 Latency SHALL be exactly NSTAGE cycles absent stalls: beat accepted on edge E is on the outputs after edge E+NSTAGE-1; each stall cycle adds one cycle.
REQ-019 Throughput SHALL be one beat per cycle with out_ready held high; beats SHALL exit in acceptance order with no loss or duplication.
REQ-020 diff, borrow, out_valid SHALL be driven directly from final-stage registers (no combinational path from a/b to outputs).
REQ-021 Borrow SHALL propagate across every slice boundary, including a full ripple from slice 0 through slice NSTAGE-1.
REQ-022 Bubble stages SHALL not affect neighbouring valid beats' data.

Reset
REQ-023 While rst=1 on an edge, all stage valid bits, data, and borrow registers SHALL clear to 0.
REQ-024 After reset: out_valid=0, diff=0, borrow=0; in_ready=1 (follows from out_valid=0).
REQ-025 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear on the outputs afterwards.
REQ-026 A beat presented in the same cycle as rst=1 SHALL NOT be accepted.

Structure
REQ-027 Shared package sub_pkg SHALL hold WIDTH/SLICE_W defaults and NSTAGE as localparam constants.
REQ-028 One sub-module sub_slice: combinational SLICE_W-bit subtract with borrow-in/borrow-out, instantiated once per stage via generate.
REQ-029 Stage registers SHALL be in sub_32bit_pipe; sub_slice SHALL contain no state.

Verification
REQ-030 a=0x00000005, b=0x00000003, out_ready=1 -> after 4 cycles diff=0x00000002, borrow=0, out_valid one cycle.
REQ-031 a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1.
REQ-032 Full ripple: a=0x01000000, b=0x00000001 -> diff=0x00FFFFFF, borrow=0; a=0x80000000, b=0x80000001 -> diff=0xFFFFFFFF, borrow=1.
REQ-033 8 back-to-back beats (a=i*0x01010101, b=i), out_ready low 3 cycles mid-stream -> in_ready low during stall, outputs held, all 8 results in order, total 11 cycles from first output.
REQ-034 3 beats in flight, rst high one cycle -> out_valid=0, diff=0 next cycle; no stale beat ever emitted; next beat after reset has 4-cycle latency.
REQ-035 Random a/b with random in_valid/out_ready, 10k beats -> scoreboard match of diff and borrow against reference a-b.
